sim_memory_model_pipe: RTL and testbench
========================================

# sim_memory_model_pipe

Parametrised simulation memory model for the mist1032isa testbench: byte-addressed store of 64-bit lines with 32-bit masked writes, a configurable fixed read latency, burst reads of 1/2/4 lines and credit-based backpressure so in-flight reads never overflow the output buffer. It sits between the core's memory port and the simulated DRAM image, loaded from a hex file at time 0. It is the next-generation model for latency and burst testing of the fetch and load/store paths.

## Interface
- P_MEM_INIT_LOAD, 1, 1 = `$readmemh` P_INIT_FILE into the array at time 0; 0 = no load.
- P_INIT_FILE, "uart.hex", image file name.
- P_ADDR_N, 26, byte-address width.
- P_MEM_LINES, 2**(P_ADDR_N-3), number of 64-bit lines.
- P_LATENCY, 1, read pipeline depth in cycles, 1..8.
- P_FIFO_DEPTH, 8, output buffer entries, power of two, ≥ 8.
- P_FIFO_DEPTH_N, 3, log2(P_FIFO_DEPTH).
- iCLOCK, in, 1, single clock; all logic on posedge.
- iRESET_SYNC, in, 1, synchronous active-high reset.
- iMEMORY_REQ, in, 1, request valid.
- oMEMORY_LOCK, out, 1, registered; 1 = request not accepted this cycle.
- iMEMORY_ORDER, in, 2, 00 byte, 01 half, 10 word, 11 none (write is a no-op).
- iMEMORY_RW, in, 1, 1 write, 0 read.
- iMEMORY_BURST, in, 2, read beats: 00 = 1, 01 = 2, 10 = 4, 11 = 1. Ignored on writes.
- iMEMORY_ADDR, in, P_ADDR_N, byte address.
- iMEMORY_DATA, in, 32, write data, lane 0 aligned.
- oMEMORY_VALID, out, 1, read data present and consumed this cycle.
- iMEMORY_LOCK, in, 1, consumer stall.
- oMEMORY_DATA, out, 64, read line.

## Operation
- Acceptance: a request is accepted when iMEMORY_REQ && !oMEMORY_LOCK.
- Write, byte enables by ADDR[1:0] and ORDER:
  - addr 0: b/h/w = 0001/0011/1111.
  - addr 1: b/h = 0010/0110.
  - addr 2: b/h = 0100/1100.
  - addr 3: any = 1000.
  - Any illegal combination = 0000.
  - Enables apply to the low word if ADDR[2] = 0, else the high word. The line is updated at the accepting edge.
- Read: line index = ADDR[P_ADDR_N-1:3]. The array is sampled in the issue cycle, so a write accepted in an earlier cycle is always visible.
- The sampled line enters a P_LATENCY-stage valid/data shift register. The stage output writes the FIFO.
- States:
  - IDLE: a read with beats > 1 → BURST, beat counter = beats−1, next index = index+1.
  - BURST: issue one beat per cycle at index, then index+1. Index wraps modulo P_MEM_LINES. When the counter reaches 0 → IDLE.
- Outstanding count = FIFO count + valid pipeline stages + remaining burst beats.
- oMEMORY_LOCK (registered) = state == BURST || outstanding > P_FIFO_DEPTH − 4. It blocks reads and writes alike.
- Pop: oMEMORY_VALID = !fifo_empty && !iMEMORY_LOCK. oMEMORY_DATA is the FIFO head; a pop occurs when VALID is high.
- Reset:
  - FIFO, pipeline and burst state are cleared; state = IDLE.
  - oMEMORY_LOCK = 0, oMEMORY_VALID = 0, oMEMORY_DATA = 0.
  - Array contents are retained.
  - A burst interrupted by reset is dropped silently.

## Timing
- Read accepted in cycle 0 with P_LATENCY = L: oMEMORY_VALID first asserts in cycle L+1, provided iMEMORY_LOCK = 0.
- Burst beats arrive on consecutive cycles. oMEMORY_LOCK is high from cycle 1 until the cycle after the last beat issues.
- Write is committed at the accept edge. A read accepted in cycle 1 returns the new data.
- FIFO full cannot occur. The bench flags an assertion if a write into a full FIFO is attempted.
- Simultaneous FIFO push and pop in one cycle leaves the count unchanged.
- iMEMORY_LOCK held indefinitely: the pipeline drains into the FIFO and oMEMORY_LOCK rises before overflow; no data is lost.

## Structure
- Package sim_memory_model_pkg holds:
  - order encodings, burst encodings, state enum {IDLE, BURST};
  - byte-enable function and mask function.
- Sub-module: the existing mist1032isa_sync_fifo, instantiated with width 64, depth P_FIFO_DEPTH, depth width P_FIFO_DEPTH_N.
- Latency pipeline, credit counter and burst FSM are in the top.

## Test plan
- Reset, then an idle cycle → LOCK = 0, VALID = 0, DATA = 0.
- Write word 0xDEADBEEF @0x10 in cycle 0, read @0x10 in cycle 1, L = 3 → VALID in cycle 5 with DATA[31:0] = 0xDEADBEEF and upper word unchanged.
- Byte write 0xAB @0x17, then line read @0x10 → DATA[63:56] = 0xAB, other bytes preserved. Write with ORDER = 11 → line unchanged.
- 4-beat burst @ last line (P_MEM_LINES−1) → four VALIDs on consecutive cycles with lines N−1, 0, 1, 2. LOCK high during the burst.
- iMEMORY_LOCK = 1, then issue reads every cycle → LOCK asserts once outstanding > 4. Release → all accepted reads return in order, none lost or duplicated.
- Reset asserted mid-burst (after beat 1) → no further VALID. LOCK = 0 the cycle after reset releases. A new read completes normally.

Source files
------------

// File: rtl/sim_memory_model_pkg.sv
// Shared encodings and lane helpers for the simulation memory model.
// Byte enables select lanes of the addressed 32-bit half of a 64-bit line.
package sim_memory_model_pkg;

   localparam logic [1:0] ORDER_BYTE = 2'b00;
   localparam logic [1:0] ORDER_HALF = 2'b01;
   localparam logic [1:0] ORDER_WORD = 2'b10;
   localparam logic [1:0] ORDER_NONE = 2'b11;

   localparam logic [1:0] BURST_1    = 2'b00;
   localparam logic [1:0] BURST_2    = 2'b01;
   localparam logic [1:0] BURST_4    = 2'b10;
   localparam logic [1:0] BURST_1_ALT = 2'b11;

   typedef enum logic {IDLE, BURST} state_t;

   function automatic logic [3:0] byte_enable(input logic [1:0] order, input logic [1:0] addr_lo);
      byte_enable = 4'b0000;
      case (addr_lo)
         2'd0: begin
            case (order)
               ORDER_BYTE: byte_enable = 4'b0001;
               ORDER_HALF: byte_enable = 4'b0011;
               ORDER_WORD: byte_enable = 4'b1111;
               default:    byte_enable = 4'b0000;
            endcase
         end
         2'd1: begin
            case (order)
               ORDER_BYTE: byte_enable = 4'b0010;
               ORDER_HALF: byte_enable = 4'b0110;
               default:    byte_enable = 4'b0000;
            endcase
         end
         2'd2: begin
            case (order)
               ORDER_BYTE: byte_enable = 4'b0100;
               ORDER_HALF: byte_enable = 4'b1100;
               default:    byte_enable = 4'b0000;
            endcase
         end
         default: begin
            if (order != ORDER_NONE) byte_enable = 4'b1000;
         end
      endcase
   endfunction

   function automatic logic [63:0] line_mask(input logic [3:0] be, input logic high_word);
      logic [7:0] lanes;
      lanes = high_word ? {be, 4'b0000} : {4'b0000, be};
      line_mask = '0;
      for (int k = 0; k < 8; k++) line_mask[k*8 +: 8] = {8{lanes[k]}};
   endfunction

   function automatic logic [2:0] burst_beats(input logic [1:0] burst);
      case (burst)
         BURST_2: burst_beats = 3'd2;
         BURST_4: burst_beats = 3'd4;
         default: burst_beats = 3'd1;
      endcase
   endfunction

endpackage

// File: rtl/mist1032isa_sync_fifo.sv
// Single-clock show-ahead FIFO; the head reads as zero while empty.
module mist1032isa_sync_fifo #(
   parameter int P_N       = 64,
   parameter int P_DEPTH   = 8,
   parameter int P_DEPTH_N = 3
) (
   input  logic           iCLOCK,
   input  logic           iRESET_SYNC,
   input  logic           iWR_EN,
   input  logic [P_N-1:0] iWR_DATA,
   input  logic           iRD_EN,
   output logic [P_N-1:0] oRD_DATA,
   output logic           oRD_EMPTY
);

   logic [P_N-1:0]     fifo_mem [0:P_DEPTH-1];
   logic [P_DEPTH_N:0] wr_ptr_reg;
   logic [P_DEPTH_N:0] rd_ptr_reg;
   logic               fifo_full;
   logic               fifo_empty;
   logic               wr_go;
   logic               rd_go;

   // Pointers carry one extra wrap bit to tell full from empty.
   assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
   assign fifo_full  = (wr_ptr_reg[P_DEPTH_N] != rd_ptr_reg[P_DEPTH_N]) &&
                       (wr_ptr_reg[P_DEPTH_N-1:0] == rd_ptr_reg[P_DEPTH_N-1:0]);
   assign wr_go      = iWR_EN && !fifo_full;
   assign rd_go      = iRD_EN && !fifo_empty;

   always_ff @(posedge iCLOCK) begin
      if (wr_go) fifo_mem[wr_ptr_reg[P_DEPTH_N-1:0]] <= iWR_DATA;
   end

   always_ff @(posedge iCLOCK) begin
      if (iRESET_SYNC) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (wr_go) wr_ptr_reg <= wr_ptr_reg + (P_DEPTH_N+1)'(1);
         if (rd_go) rd_ptr_reg <= rd_ptr_reg + (P_DEPTH_N+1)'(1);
      end
   end

   assign oRD_DATA  = fifo_empty ? '0 : fifo_mem[rd_ptr_reg[P_DEPTH_N-1:0]];
   assign oRD_EMPTY = fifo_empty;

endmodule

// File: rtl/sim_memory_model_pipe.sv
// Line-organised memory model with fixed read latency, 1/2/4-beat bursts and
// credit-based request throttling so the output FIFO can never overflow.
module sim_memory_model_pipe
   import sim_memory_model_pkg::*;
#(
   parameter int    P_MEM_INIT_LOAD = 1,
   parameter string P_INIT_FILE     = "uart.hex",
   parameter int    P_ADDR_N        = 26,
   parameter int    P_MEM_LINES     = 2**(P_ADDR_N-3),
   parameter int    P_LATENCY       = 1,
   parameter int    P_FIFO_DEPTH    = 8,
   parameter int    P_FIFO_DEPTH_N  = 3
) (
   input  logic                iCLOCK,
   input  logic                iRESET_SYNC,
   input  logic                iMEMORY_REQ,
   output logic                oMEMORY_LOCK,
   input  logic [1:0]          iMEMORY_ORDER,
   input  logic                iMEMORY_RW,
   input  logic [1:0]          iMEMORY_BURST,
   input  logic [P_ADDR_N-1:0] iMEMORY_ADDR,
   input  logic [31:0]         iMEMORY_DATA,
   output logic                oMEMORY_VALID,
   input  logic                iMEMORY_LOCK,
   output logic [63:0]         oMEMORY_DATA
);

   localparam int LINE_N   = P_ADDR_N - 3;
   localparam int CREDIT_N = P_FIFO_DEPTH_N + 1;
   localparam logic [CREDIT_N-1:0] LOCK_LEVEL = CREDIT_N'(P_FIFO_DEPTH - 4);

   logic [63:0] mem_array [0:P_MEM_LINES-1];

   state_t              state_reg;
   logic [1:0]          beat_cnt_reg;
   logic [LINE_N-1:0]   burst_idx_reg;
   logic [CREDIT_N-1:0] credit_reg;
   logic [CREDIT_N-1:0] credit_next;
   logic                lock_reg;

   logic                accept, acc_read, acc_write;
   logic                burst_start, burst_last, issue, pop;
   logic [2:0]          req_beats;
   logic [LINE_N-1:0]   req_idx, issue_idx;
   logic [31:0]         word_shifted;
   logic [63:0]         wr_mask, wr_line;

   logic                stage_valid_reg [0:P_LATENCY-1];
   logic [63:0]         stage_data_reg  [0:P_LATENCY-1];
   logic                fifo_push;
   logic                fifo_empty;
   logic [63:0]         fifo_rdata;

   function automatic logic [LINE_N-1:0] next_line(input logic [LINE_N-1:0] idx);
      next_line = (idx == LINE_N'(P_MEM_LINES - 1)) ? '0 : idx + LINE_N'(1);
   endfunction

   assign req_idx      = iMEMORY_ADDR[P_ADDR_N-1:3];
   assign accept       = iMEMORY_REQ && !lock_reg;
   assign acc_read     = accept && !iMEMORY_RW;
   assign acc_write    = accept && iMEMORY_RW;
   assign req_beats    = burst_beats(iMEMORY_BURST);
   assign burst_start  = acc_read && (state_reg == IDLE) && (req_beats != 3'd1);
   assign burst_last   = (state_reg == BURST) && (beat_cnt_reg == 2'd1);
   assign issue        = acc_read || (state_reg == BURST);
   assign issue_idx    = (state_reg == BURST) ? burst_idx_reg : req_idx;
   assign pop          = !fifo_empty && !iMEMORY_LOCK;

   // Credits cover every beat from acceptance until it leaves the FIFO, which
   // equals FIFO occupancy + valid pipeline stages + unissued burst beats.
   assign credit_next  = credit_reg + (acc_read ? CREDIT_N'(req_beats) : '0) - (pop ? CREDIT_N'(1) : '0);

   assign word_shifted = iMEMORY_DATA << {iMEMORY_ADDR[1:0], 3'b000};
   assign wr_line      = {word_shifted, word_shifted};
   assign wr_mask      = line_mask(byte_enable(iMEMORY_ORDER, iMEMORY_ADDR[1:0]), iMEMORY_ADDR[2]);

   always_ff @(posedge iCLOCK) begin
      if (acc_write) mem_array[req_idx] <= (mem_array[req_idx] & ~wr_mask) | (wr_line & wr_mask);
   end

   always_ff @(posedge iCLOCK) begin
      stage_data_reg[0] <= mem_array[issue_idx];
   end

   always_ff @(posedge iCLOCK) begin
      if (iRESET_SYNC) stage_valid_reg[0] <= 1'b0;
      else             stage_valid_reg[0] <= issue;
   end

   generate
      for (genvar gi = 1; gi < P_LATENCY; gi++) begin : g_stage
         always_ff @(posedge iCLOCK) begin
            if (iRESET_SYNC) stage_valid_reg[gi] <= 1'b0;
            else             stage_valid_reg[gi] <= stage_valid_reg[gi-1];
            stage_data_reg[gi] <= stage_data_reg[gi-1];
         end
      end
   endgenerate

   assign fifo_push = stage_valid_reg[P_LATENCY-1];

   always_ff @(posedge iCLOCK) begin
      if (iRESET_SYNC) begin
         state_reg     <= IDLE;
         beat_cnt_reg  <= '0;
         burst_idx_reg <= '0;
         credit_reg    <= '0;
         lock_reg      <= 1'b0;
      end else begin
         credit_reg <= credit_next;
         // Lock follows the next-cycle state so no request slips in on burst entry.
         lock_reg   <= burst_start || ((state_reg == BURST) && !burst_last) || (credit_next > LOCK_LEVEL);
         case (state_reg)
            IDLE: begin
               if (burst_start) begin
                  state_reg     <= BURST;
                  beat_cnt_reg  <= 2'(req_beats - 3'd1);
                  burst_idx_reg <= next_line(req_idx);
               end
            end
            BURST: begin
               beat_cnt_reg  <= beat_cnt_reg - 2'd1;
               burst_idx_reg <= next_line(burst_idx_reg);
               if (burst_last) state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   mist1032isa_sync_fifo #(
      .P_N       (64),
      .P_DEPTH   (P_FIFO_DEPTH),
      .P_DEPTH_N (P_FIFO_DEPTH_N)
   ) u_fifo (
      .iCLOCK      (iCLOCK),
      .iRESET_SYNC (iRESET_SYNC),
      .iWR_EN      (fifo_push),
      .iWR_DATA    (stage_data_reg[P_LATENCY-1]),
      .iRD_EN      (pop),
      .oRD_DATA    (fifo_rdata),
      .oRD_EMPTY   (fifo_empty)
   );

   assign oMEMORY_LOCK  = lock_reg;
   assign oMEMORY_VALID = pop;
   assign oMEMORY_DATA  = fifo_rdata;

endmodule

// File: tb/tb_sim_memory_model_pipe.sv
// Directed and random checks of the memory model against a line-array model
// with an expected-read queue.
module tb_sim_memory_model_pipe;

   localparam int ADDR_N = 10;
   localparam int LINES  = 128;
   localparam int LAT    = 3;

   logic              iCLOCK = 1'b0;
   logic              srst;
   logic              req, rw, cons_lock;
   logic [1:0]        order, burst;
   logic [ADDR_N-1:0] addr;
   logic [31:0]       wdata;
   logic              lock_o, valid_o;
   logic [63:0]       data_o;

   always #5 iCLOCK = ~iCLOCK;

   sim_memory_model_pipe #(
      .P_MEM_INIT_LOAD (0),
      .P_INIT_FILE     ("uart.hex"),
      .P_ADDR_N        (ADDR_N),
      .P_MEM_LINES     (LINES),
      .P_LATENCY       (LAT),
      .P_FIFO_DEPTH    (8),
      .P_FIFO_DEPTH_N  (3)
   ) u_dut (
      .iCLOCK        (iCLOCK),
      .iRESET_SYNC   (srst),
      .iMEMORY_REQ   (req),
      .oMEMORY_LOCK  (lock_o),
      .iMEMORY_ORDER (order),
      .iMEMORY_RW    (rw),
      .iMEMORY_BURST (burst),
      .iMEMORY_ADDR  (addr),
      .iMEMORY_DATA  (wdata),
      .oMEMORY_VALID (valid_o),
      .iMEMORY_LOCK  (cons_lock),
      .oMEMORY_DATA  (data_o)
   );

   int          n_assert = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          valid_cnt = 0;
   logic [63:0] model [0:LINES-1];
   logic [63:0] exp_q[$];
   int          valid_cyc_q[$];
   logic [63:0] last_data = '0;

   always @(posedge iCLOCK) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Enabled bytes: a naturally sized access that fits in the word, except
   // that any sized access at offset 3 touches byte 3 only.
   function automatic void model_write(input logic [ADDR_N-1:0] a, input logic [1:0] o, input logic [31:0] d);
      int off, size, first, last, line, base;
      off  = int'(a[1:0]);
      line = int'(a[ADDR_N-1:3]);
      base = a[2] ? 4 : 0;
      size = (o == 2'b00) ? 1 : (o == 2'b01) ? 2 : (o == 2'b10) ? 4 : 0;
      if (size == 0) return;
      if (off == 3) begin
         first = 3; last = 3;
      end else if (off + size > 4) begin
         return;
      end else begin
         first = off; last = off + size - 1;
      end
      for (int k = first; k <= last; k++) model[line][(base+k)*8 +: 8] = d[(k-off)*8 +: 8];
   endfunction

   task automatic drive(input logic r, input logic w, input logic [1:0] o, input logic [1:0] b,
                        input logic [ADDR_N-1:0] a, input logic [31:0] d,
                        output logic acc, output int acc_cyc, output logic lock_seen);
      int nb, ln;
      req = r; rw = w; order = o; burst = b; addr = a; wdata = d;
      @(negedge iCLOCK);
      lock_seen = lock_o;
      acc       = r && !lock_o;
      acc_cyc   = cyc;
      if (acc) begin
         if (w) model_write(a, o, d);
         else begin
            nb = (b == 2'b01) ? 2 : (b == 2'b10) ? 4 : 1;
            ln = int'(a[ADDR_N-1:3]);
            for (int i = 0; i < nb; i++) exp_q.push_back(model[(ln + i) % LINES]);
         end
      end
      @(posedge iCLOCK);
      #1;
      req = 1'b0;
   endtask

   task automatic idle(input int n);
      logic a_, l_;
      int   c_;
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 2'b00, 2'b00, '0, '0, a_, c_, l_);
   endtask

   task automatic drain(input string tag);
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 200) begin
         idle(1);
         t++;
      end
      idle(2);
      check(tag, 64'(exp_q.size()), 64'd0);
   endtask

   always @(negedge iCLOCK) begin
      if (!srst) begin
         if (u_dut.fifo_push) check("fifo_push_when_full", 64'(u_dut.u_fifo.fifo_full), 64'd0);
         if (valid_o) begin
            valid_cnt++;
            valid_cyc_q.push_back(cyc);
            last_data = data_o;
            n_assert++;
            assert (exp_q.size() != 0) else begin
               n_fail++;
               $error("FAIL spurious_valid: observed data %h expected no valid", data_o);
            end
            if (exp_q.size() != 0) check("read_data", data_o, exp_q.pop_front());
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic        acc, lk;
      int          c, n_acc, base;
      logic [63:0] prev, expl;

      srst = 1'b1; req = 1'b0; rw = 1'b0; order = 2'b00; burst = 2'b00;
      addr = '0; wdata = '0; cons_lock = 1'b0;
      repeat (3) @(posedge iCLOCK);
      #1;
      srst = 1'b0;

      // Reset state after an idle cycle
      idle(1);
      @(negedge iCLOCK);
      check("reset_lock",  64'(lock_o),  64'd0);
      check("reset_valid", 64'(valid_o), 64'd0);
      check("reset_data",  data_o,       64'd0);
      @(posedge iCLOCK);
      #1;

      // Fill the whole array with known random words
      for (int ln = 0; ln < LINES; ln++) begin
         for (int w = 0; w < 2; w++) begin
            drive(1'b1, 1'b1, 2'b10, 2'b00, ADDR_N'(ln*8 + w*4), $urandom, acc, c, lk);
            if (ln == 0 || ln == LINES-1) check("init_write_accept", 64'(acc), 64'd1);
         end
      end

      // Write then immediate read, latency L
      drive(1'b1, 1'b1, 2'b10, 2'b00, ADDR_N'('h10), 32'hDEADBEEF, acc, c, lk);
      valid_cyc_q.delete();
      drive(1'b1, 1'b0, 2'b00, 2'b00, ADDR_N'('h10), '0, acc, c, lk);
      idle(LAT + 3);
      check("lat_count",  64'(valid_cyc_q.size()), 64'd1);
      check("lat_cycles", 64'(valid_cyc_q[0] - c), 64'(LAT + 1));
      check("lat_low",    64'(last_data[31:0]),  64'h00000000DEADBEEF);
      check("lat_high",   64'(last_data[63:32]), 64'(model[2][63:32]));

      // Byte write into the top byte of line 2
      prev = model[2];
      drive(1'b1, 1'b1, 2'b00, 2'b00, ADDR_N'('h17), 32'h000000AB, acc, c, lk);
      drive(1'b1, 1'b0, 2'b00, 2'b00, ADDR_N'('h10), '0, acc, c, lk);
      idle(LAT + 3);
      check("byte_hi",   64'(last_data[63:56]), 64'hAB);
      check("byte_rest", 64'(last_data[55:0]),  64'(prev[55:0]));

      // Half write at offset 1, then an illegal word at offset 2 and ORDER none
      prev = model[2];
      expl = prev;
      expl[23:8] = 16'h1234;
      drive(1'b1, 1'b1, 2'b01, 2'b00, ADDR_N'('h11), 32'h00001234, acc, c, lk);
      drive(1'b1, 1'b1, 2'b10, 2'b00, ADDR_N'('h12), $urandom, acc, c, lk);
      drive(1'b1, 1'b1, 2'b11, 2'b00, ADDR_N'('h10), $urandom, acc, c, lk);
      drive(1'b1, 1'b0, 2'b00, 2'b00, ADDR_N'('h10), '0, acc, c, lk);
      idle(LAT + 3);
      check("half_and_noop", last_data, expl);

      // 4-beat burst wrapping from the last line
      valid_cyc_q.delete();
      drive(1'b1, 1'b0, 2'b00, 2'b10, ADDR_N'((LINES-1)*8), '0, acc, c, lk);
      check("burst_accept", 64'(acc), 64'd1);
      for (int i = 0; i < 3; i++) begin
         idle(0);
         drive(1'b1, 1'b1, 2'b10, 2'b00, ADDR_N'('h40), $urandom, acc, n_acc, lk);
         check("burst_lock", 64'(lk), 64'd1);
      end
      idle(LAT + 4);
      check("burst_count", 64'(valid_cyc_q.size()), 64'd4);
      for (int i = 0; i < 4; i++) check("burst_cycle", 64'(valid_cyc_q[i]), 64'(c + LAT + 1 + i));
      check("burst_last_line", last_data, model[2]);

      // Consumer stall: reads every cycle until the credit limit locks
      drain("pre_bp_drain");
      base = valid_cnt;
      cons_lock = 1'b1;
      n_acc = 0;
      for (int i = 0; i < 12; i++) begin
         drive(1'b1, 1'b0, 2'b00, 2'b00, ADDR_N'($urandom_range(0, 1023)), '0, acc, c, lk);
         if (acc) n_acc++;
      end
      check("bp_accepted", 64'(n_acc), 64'd5);
      check("bp_lock",     64'(lk),    64'd1);
      check("bp_no_valid", 64'(valid_cnt - base), 64'd0);
      cons_lock = 1'b0;
      drain("bp_drain");
      check("bp_returned", 64'(valid_cnt - base), 64'd5);

      // Random traffic with random consumer stalls
      for (int i = 0; i < 400; i++) begin
         cons_lock = ($urandom_range(0, 3) == 0);
         drive($urandom_range(0, 9) < 6, $urandom_range(0, 2) == 0,
               2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
               ADDR_N'($urandom_range(0, 1023)), $urandom, acc, c, lk);
      end
      cons_lock = 1'b0;
      drain("rand_drain");

      // Reset in the middle of a burst
      base = valid_cnt;
      drive(1'b1, 1'b0, 2'b00, 2'b10, ADDR_N'('h28), '0, acc, c, lk);
      check("rst_burst_accept", 64'(acc), 64'd1);
      idle(1);
      srst = 1'b1;
      exp_q.delete();
      idle(1);
      srst = 1'b0;
      @(negedge iCLOCK);
      check("rst_lock", 64'(lock_o), 64'd0);
      @(posedge iCLOCK);
      #1;
      idle(10);
      check("rst_no_valid", 64'(valid_cnt - base), 64'd0);
      drive(1'b1, 1'b0, 2'b00, 2'b00, ADDR_N'('h30), '0, acc, c, lk);
      check("rst_new_accept", 64'(acc), 64'd1);
      drain("rst_new_drain");
      check("rst_new_count", 64'(valid_cnt - base), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
